// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU program-load path: loader states, NOP word, default depth.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CLEAR,
        BURST,
        FLUSH,
        RUN
    } state_t;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam int          LOAD_DEPTH = 32;

endpackage

// File: rtl/prog_buf.sv
// Program word store: DEPTH x 32 register array, synchronous write, asynchronous read.
module prog_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Program loader: buffers a streamed program, then replays it gap-free into the CPU's load port.
// Define PROG_LOADER_PAD_EN to append up to PAD_WORDS NOPs after the program.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH     = LOAD_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int PAD_WORDS = 4
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          cpu_reset,
    output logic          cpu_load,
    output logic [31:0]   cpu_instr,
    output logic [AW:0]   word_count,
    output logic          busy,
    output logic          overflow
);

`ifdef PROG_LOADER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] PAD_W   = (AW+1)'(PAD_WORDS);

    state_t        state_q;
    logic [AW:0]   wordCount_q;
    logic [AW:0]   wordCount_d;
    logic [AW-1:0] rdIdx_q;
    logic [AW:0]   rdIdx_d;
    logic          flush_q;
    logic          overflow_q;
    logic          inReady_q;
    logic          cpuReset_q;
    logic          cpuLoad_q;
    logic [31:0]   cpuInstr_q;

    logic          accept;
    logic [AW:0]   room;
    logic [AW:0]   padLen;
    logic [AW:0]   burstLen;
    logic [AW-1:0] rdAddr;
    logic [31:0]   bufData;

    assign accept      = (state_q == FILL) && in_valid && inReady_q;
    assign wordCount_d = wordCount_q + 1'b1;
    assign rdIdx_d     = {1'b0, rdIdx_q} + 1'b1;

    // The read port looks one word ahead so cpu_instr can be registered.
    assign rdAddr = (state_q == BURST) ? rdIdx_d[AW-1:0] : '0;

    // Padding is clipped so the CPU never receives more than DEPTH words.
    always_comb begin
        room   = DEPTH_W - wordCount_q;
        padLen = '0;
        if (PAD_EN) begin
            padLen = (room < PAD_W) ? room : PAD_W;
        end
        burstLen = wordCount_q + padLen;
    end

    prog_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (accept),
        .waddr_i (wordCount_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (rdAddr),
        .rdata_o (bufData)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            wordCount_q <= '0;
            rdIdx_q     <= '0;
            flush_q     <= 1'b0;
            overflow_q  <= 1'b0;
            inReady_q   <= 1'b0;
            cpuReset_q  <= 1'b1;
            cpuLoad_q   <= 1'b0;
            cpuInstr_q  <= NOP_WORD;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (start) begin
                        state_q     <= FILL;
                        wordCount_q <= '0;
                        overflow_q  <= 1'b0;
                        inReady_q   <= 1'b1;
                        cpuReset_q  <= 1'b1;
                        cpuLoad_q   <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        wordCount_q <= wordCount_d;
                        if (in_last) begin
                            state_q   <= CLEAR;
                            inReady_q <= 1'b0;
                        end else begin
                            inReady_q <= (wordCount_d < DEPTH_W);
                        end
                    end else if (in_valid && !inReady_q) begin
                        overflow_q <= 1'b1;
                        state_q    <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_q    <= BURST;
                    rdIdx_q    <= '0;
                    cpuReset_q <= 1'b0;
                    cpuLoad_q  <= 1'b1;
                    cpuInstr_q <= bufData;
                end
                BURST: begin
                    if (rdIdx_d == burstLen) begin
                        state_q    <= FLUSH;
                        flush_q    <= 1'b0;
                        cpuReset_q <= 1'b1;
                        cpuLoad_q  <= 1'b0;
                        cpuInstr_q <= NOP_WORD;
                    end else begin
                        rdIdx_q    <= rdIdx_d[AW-1:0];
                        cpuInstr_q <= (rdIdx_d < wordCount_q) ? bufData : NOP_WORD;
                    end
                end
                FLUSH: begin
                    if (flush_q) begin
                        state_q    <= RUN;
                        cpuReset_q <= 1'b0;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = inReady_q;
    assign cpu_reset  = cpuReset_q;
    assign cpu_load   = cpuLoad_q;
    assign cpu_instr  = cpuInstr_q;
    assign word_count = wordCount_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE) && (state_q != RUN);

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the pipelined CPU's instruction-load path. Buffers a program arriving on a valid/ready stream, then drives the CPU's Reset, LoadInstructions and Instruction pins so the CPU stores the program.
- The CPU's load-address counter advances on every clock, so the block replays the buffer as a gap-free burst, one word per cycle.
- Releases the CPU to run after the burst.

Parameters:
- DEPTH, 32, maximum program words held; must be a power of 2, ≥2.
- AW, $clog2(DEPTH), buffer index width.
- PAD_WORDS, 4, NOP words appended when PROG_LOADER_PAD_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse in IDLE or RUN begins a new load session.
- in_valid  in  1  source word valid.
- in_data  in  32  source instruction word.
- in_last  in  1  marks the final word of the program.
- in_ready  out  1  block accepts a word this cycle.
- cpu_reset  out  1  drives CPU Reset.
- cpu_load  out  1  drives CPU LoadInstructions.
- cpu_instr  out  32  drives CPU Instruction.
- word_count  out  AW+1  number of words buffered in this session.
- busy  out  1  high in any state other than IDLE or RUN.
- overflow  out  1  sticky: source offered a word while the buffer was full.

Behaviour:
- States: IDLE, FILL, CLEAR, BURST, FLUSH, RUN. Registered FSM; all outputs are registered or decoded from state and counters only.
- Reset (async): state=IDLE. cpu_reset=1, cpu_load=0, cpu_instr=0, word_count=0, overflow=0, in_ready=0. The CPU is held in reset while the loader is idle.
- IDLE: cpu_reset=1. On start -> FILL, clear word_count and overflow.
- FILL:
  - in_ready=1 while word_count<DEPTH.
  - A transfer occurs when in_valid & in_ready. Write in_data to buf[word_count] and increment word_count.
  - A transfer with in_last -> CLEAR next cycle.
  - If word_count==DEPTH and in_valid=1 without in_last being accepted: set overflow and go -> CLEAR, truncating the program to DEPTH words.
  - in_ready drops to 0 the cycle after the last accepted word.
- CLEAR: exactly 1 cycle; cpu_reset=1, cpu_load=0. This zeroes the CPU's load-address counter. -> BURST.
- BURST:
  - cpu_reset=0, cpu_load=1, cpu_instr=buf[rd_idx], with rd_idx=0 on the first BURST cycle and +1 per cycle.
  - Lasts exactly word_count cycles (plus padding, see Optional Feature), with no bubbles.
  - CPU address k receives buf[k].
  - -> FLUSH after the final word.
- FLUSH: exactly 2 cycles; cpu_reset=1, cpu_load=0, cpu_instr=0. Resets the PC and pipeline registers. -> RUN.
- RUN: cpu_reset=0, cpu_load=0. Stays until start, which goes -> FILL and immediately sets cpu_reset=1 for the whole reload.
- Empty program: in_last on the first word counts as one word. A zero-word program is impossible.
- start during busy is ignored.
- in_last while in_valid=0 is ignored.
- Simultaneous overflow and in_last on the same cycle: treated as overflow; the word is not stored.
- Reset asserted mid-BURST: immediate IDLE. The CPU program is considered invalid; a new start is required.
- Buffer RAM is not reset; only the control registers are.

Optional Feature:
- PROG_LOADER_PAD_EN defined: BURST is followed by PAD_WORDS extra cycles with cpu_load=1 and cpu_instr=32'h0000_0000 (NOP). Padding is clipped so total loaded words ≤ DEPTH. This guarantees that pipeline fetch past the program end sees NOPs.
- Undefined: no padding; BURST length equals word_count exactly.

Decomposition:
- Shared package cpu_pkg: state encoding enum (IDLE..RUN), NOP_WORD constant, LOAD_DEPTH default (32).
- One sub-module: prog_buf, a simple dual-port DEPTH×32 register array with a synchronous write port and an asynchronous read port. It holds no control logic.

Test Plan:
1. 3-word program, no padding:
   - Stimulus: start, then 32'h2001_0005, 32'h2002_0003, 32'h0022_1820 (in_last on the third), in_valid held high.
   - Required response: in_ready high for 3 cycles; CLEAR 1 cycle; cpu_load high exactly 3 consecutive cycles carrying those words in order; cpu_reset high 2 cycles; then RUN with cpu_reset=0; word_count=3.
2. Source stalls:
   - Stimulus: same program with in_valid toggling 1,0,0,1,0,1.
   - Required response: BURST is still 3 back-to-back cycles with no gaps; order is preserved.
3. Overflow:
   - Stimulus: DEPTH=4, send 6 words, in_last on the sixth.
   - Required response: 4 words stored; overflow=1 and sticky; burst length 4.
4. Reset during BURST:
   - Stimulus: assert Reset asynchronously on the second burst word.
   - Required response: outputs go to reset values within the same cycle (cpu_reset=1, cpu_load=0); state=IDLE; a subsequent start reloads correctly.
5. Padding, with PROG_LOADER_PAD_EN and PAD_WORDS=4:
   - Stimulus: 2-word program.
   - Required response: 6 load cycles, the last 4 carrying 32'h0.
   - Stimulus: a DEPTH-1 word program.
   - Required response: only 1 pad word.
6. Reload from RUN, and start ignored while busy:
   - Stimulus: start while in RUN.
   - Required response: cpu_reset=1 on the next cycle, word_count cleared, new program loaded.
   - Stimulus: start pulse during FILL.
   - Required response: no effect.
